// File: rtl/shift_sequencer_if.sv
// Shift sequencer bundle: two valid/ready request channels and one held response channel.
// Latency: none, wires only.
// Backpressure: reqN_ready driven by the sequencer; resp_ready driven by the consumer.
// Ports: req0_*/req1_* (valid, ready, op, data, amount), resp_* (valid, ready, id, result).
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_data;
  logic [4:0]       req0_amount;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_data;
  logic [4:0]       req1_amount;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;

  // Requesters and response consumer.
  modport master (
    output req0_valid, req0_op, req0_data, req0_amount,
    output req1_valid, req1_op, req1_data, req1_amount,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_result
  );

  // Shift sequencer.
  modport slave (
    input  req0_valid, req0_op, req0_data, req0_amount,
    input  req1_valid, req1_op, req1_data, req1_amount,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin shared 32-bit shifter (SLL/SRL/SRA/ROR), one power-of-two stage per cycle.
// Latency: accept at t -> resp_valid at t+1+N, N = msb(amount)+1 (EARLY_EXIT) or 5; N=0 for amount 0.
// Backpressure: one op in flight, readys low outside IDLE; result held until resp_ready.
// Ports: clock, reset_n (async active-low), bus (slave modport of shift_sequencer_if), busy.
module shift_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  shift_sequencer_if.slave  bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       amt_q, amt_d;
  logic             id_q, id_d;
  logic [2:0]       k_q, k_d;
  logic             rr_q, rr_d;
  logic             grant;
  logic             last_stage;

  // One shift stage. The callers only pass loop constants for sh, so each
  // instance reduces to fixed wiring rather than a barrel shifter.
  // SRA: acc[31] never changes under SRA, so it always holds the original sign.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] v,
                                                   input int sh);
    case (op)
      OP_SLL:  return v << sh;
      OP_SRL:  return v >> sh;
      OP_SRA:  return $signed(v) >>> sh;
      default: return (v >> sh) | (v << (WIDTH - sh));
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      acc_q   <= '0;
      amt_q   <= 5'd0;
      id_q    <= 1'b0;
      k_q     <= 3'd0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      id_q    <= id_d;
      k_q     <= k_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    acc_d          = acc_q;
    amt_d          = amt_q;
    id_d           = id_q;
    k_d            = k_q;
    rr_d           = rr_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.resp_valid = 1'b0;
    // A lone valid requester wins outright; rr_q only breaks ties.
    grant          = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
    // Early exit: nothing left to do once no higher amount bit is set.
    last_stage     = EARLY_EXIT ? ((amt_q >> (k_q + 3'd1)) == 5'd0) : (k_q == 3'd4);

    case (state_q)
      S_IDLE: begin
        // reset_n gate keeps both readys low while reset is held.
        if (reset_n && (bus.req0_valid || bus.req1_valid)) begin
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          op_d  = grant ? bus.req1_op     : bus.req0_op;
          acc_d = grant ? bus.req1_data   : bus.req0_data;
          amt_d = grant ? bus.req1_amount : bus.req0_amount;
          id_d  = grant;
          rr_d  = ~grant;
          k_d   = 3'd0;
          state_d = ((grant ? bus.req1_amount : bus.req0_amount) == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        for (int i = 0; i < 5; i++) begin
          if (k_q == 3'(i) && amt_q[i]) acc_d = stage_shift(op_q, acc_q, 1 << i);
        end
        k_d = k_q + 3'd1;
        if (last_stage) state_d = S_DONE;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_result = acc_q;
  assign bus.resp_id     = id_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  logic clock = 1'b0;
  logic reset_n;
  logic busy0, busy1;
  always #5 clock = ~clock;

  shift_sequencer_if #(.WIDTH(32)) b0();
  shift_sequencer_if #(.WIDTH(32)) b1();

  shift_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0), .busy(busy0));
  shift_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1), .busy(busy1));

  typedef struct {
    int          d;
    logic        id;
    logic [31:0] res;
    int          t;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        prev_v[2];
  logic        prev_r[2];
  logic        prev_id[2];
  logic [31:0] prev_res[2];

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] dt, input logic [4:0] a);
    case (op)
      2'b00:   return dt << a;
      2'b01:   return dt >> a;
      2'b10:   return $signed(dt) >>> a;
      default: return (a == 5'd0) ? dt : ((dt >> a) | (dt << (6'd32 - {1'b0, a})));
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] a, input int ee);
    if (a == 5'd0) return 1;
    if (ee == 0) return 6;
    for (int i = 4; i >= 0; i--) if (a[i]) return i + 2;
    return 1;
  endfunction

  function automatic int find(input int d);
    foreach (sb[i]) if (sb[i].d == d) return i;
    return -1;
  endfunction

  task automatic mon(input int d, input logic bsy,
                     input logic v0, r0, input logic [1:0] op0, input logic [31:0] dt0, input logic [4:0] a0,
                     input logic v1, r1, input logic [1:0] op1, input logic [31:0] dt1, input logic [4:0] a1,
                     input logic rv, rr, rid, input logic [31:0] res);
    int   idx;
    logic pend;
    exp_t e;
    pend = (find(d) >= 0);
    chk($sformatf("busy%0d", d), bsy, pend);
    if (pend && (r0 || r1)) chk($sformatf("rdy_while_busy%0d", d), {r0, r1}, 2'b00);
    if (v0 && v1) chk($sformatf("rdy_excl%0d", d), r0 & r1, 1'b0);
    if ((v0 && r0) || (v1 && r1)) begin
      e.d   = d;
      e.id  = (v1 && r1);
      e.res = e.id ? model(op1, dt1, a1) : model(op0, dt0, a0);
      e.lat = lat_of(e.id ? a1 : a0, d == 0 ? 1 : 0);
      e.t   = cyc;
      sb.push_back(e);
    end
    if (prev_v[d] && !prev_r[d]) begin
      chk($sformatf("stall_valid%0d", d), rv, 1'b1);
      chk($sformatf("stall_result%0d", d), res, prev_res[d]);
      chk($sformatf("stall_id%0d", d), rid, prev_id[d]);
    end
    if (rv && !prev_v[d]) begin
      idx = find(d);
      if (idx < 0) chk($sformatf("spurious_resp%0d", d), rv, 1'b0);
      else chk($sformatf("latency%0d", d), cyc - sb[idx].t, sb[idx].lat);
    end
    if (rv && rr) begin
      idx = find(d);
      if (idx >= 0) begin
        chk($sformatf("result%0d", d), res, sb[idx].res);
        chk($sformatf("resp_id%0d", d), rid, sb[idx].id);
        sb.delete(idx);
      end
    end
    prev_v[d]   = rv;
    prev_r[d]   = rr;
    prev_id[d]  = rid;
    prev_res[d] = res;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      mon(0, busy0, b0.req0_valid, b0.req0_ready, b0.req0_op, b0.req0_data, b0.req0_amount,
          b0.req1_valid, b0.req1_ready, b0.req1_op, b0.req1_data, b0.req1_amount,
          b0.resp_valid, b0.resp_ready, b0.resp_id, b0.resp_result);
      mon(1, busy1, b1.req0_valid, b1.req0_ready, b1.req0_op, b1.req0_data, b1.req0_amount,
          b1.req1_valid, b1.req1_ready, b1.req1_op, b1.req1_data, b1.req1_amount,
          b1.resp_valid, b1.resp_ready, b1.resp_id, b1.resp_result);
    end
  end

  task automatic set_req(input int d, input int p, input logic v, input logic [1:0] op,
                         input logic [31:0] dt, input logic [4:0] a);
    if (d == 0 && p == 0) begin
      b0.req0_valid = v; b0.req0_op = op; b0.req0_data = dt; b0.req0_amount = a;
    end else if (d == 0) begin
      b0.req1_valid = v; b0.req1_op = op; b0.req1_data = dt; b0.req1_amount = a;
    end else if (p == 0) begin
      b1.req0_valid = v; b1.req0_op = op; b1.req0_data = dt; b1.req0_amount = a;
    end else begin
      b1.req1_valid = v; b1.req1_op = op; b1.req1_data = dt; b1.req1_amount = a;
    end
  endtask

  function automatic logic rdy(input int d, input int p);
    if (d == 0) return (p == 0) ? b0.req0_ready : b0.req1_ready;
    return (p == 0) ? b1.req0_ready : b1.req1_ready;
  endfunction

  // Wait at negedges for an accept on port (d,p), then drop valid and scramble
  // the operand so any late sampling would corrupt the result.
  task automatic wait_acc(input int d, input int p);
    int n = 0;
    do begin @(negedge clock); n++; end while (!rdy(d, p) && n < 100);
    if (!rdy(d, p)) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clock); #1;
    set_req(d, p, 1'b0, 2'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic issue(input int d, input int p, input logic [1:0] op, input logic [31:0] dt, input logic [4:0] a);
    @(posedge clock); #1;
    set_req(d, p, 1'b1, op, dt, a);
    wait_acc(d, p);
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (find(d) >= 0 && n < 200) begin @(negedge clock); n++; end
    if (find(d) >= 0) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      prev_v[d] = 1'b0; prev_r[d] = 1'b0; prev_id[d] = 1'b0; prev_res[d] = '0;
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 2'b00, 32'h0, 5'd0);
    end
    b0.resp_ready = 1'b1;
    b1.resp_ready = 1'b1;
    set_req(0, 0, 1'b1, 2'b00, 32'h1, 5'd1);
    set_req(0, 1, 1'b1, 2'b00, 32'h1, 5'd1);
    repeat (3) @(posedge clock);
    #2;
    chk("rst_resp_valid", b0.resp_valid, 1'b0);
    chk("rst_resp_id", b0.resp_id, 1'b0);
    chk("rst_resp_result", b0.resp_result, 32'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_readys", {b0.req0_ready, b0.req1_ready}, 2'b00);
    set_req(0, 0, 1'b0, 2'b00, 32'h0, 5'd0);
    set_req(0, 1, 1'b0, 2'b00, 32'h0, 5'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Directed ops; monitor checks result, id and latency.
    issue(0, 0, 2'b10, 32'h8000_0000, 5'd4);
    wait_drain(0);
    issue(0, 1, 2'b00, 32'h0000_0001, 5'd31);
    wait_drain(0);
    issue(0, 0, 2'b01, 32'h8000_0000, 5'd31);
    wait_drain(0);
    issue(0, 1, 2'b11, 32'h0000_000F, 5'd4);
    wait_drain(0);
    issue(0, 0, 2'b10, 32'h1234_5678, 5'd0);
    wait_drain(0);

    // Response stall for 3 cycles in DONE while req1 waits.
    b0.resp_ready = 1'b0;
    issue(0, 0, 2'b00, 32'h0000_00A5, 5'd3);
    set_req(0, 1, 1'b1, 2'b01, 32'hDEAD_BEEF, 5'd7);
    n = 0;
    do begin @(negedge clock); n++; end while (!b0.resp_valid && n < 20);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clock);
      chk("stall_rv", b0.resp_valid, 1'b1);
      chk("stall_readys", {b0.req0_ready, b0.req1_ready}, 2'b00);
    end
    @(posedge clock); #1;
    b0.resp_ready = 1'b1;
    @(negedge clock);
    chk("stall_4th_rv", b0.resp_valid, 1'b1);
    wait_acc(0, 1);
    wait_drain(0);

    // Reset asserted mid-SHIFT.
    issue(0, 0, 2'b00, 32'h0000_0001, 5'd31);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", b0.resp_valid, 1'b0);
    chk("mid_rst_resp_result", b0.resp_result, 32'h0);
    chk("mid_rst_resp_id", b0.resp_id, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    sb.delete();
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    set_req(0, 0, 1'b1, 2'b01, 32'hF0F0_0000, 5'd8);
    set_req(0, 1, 1'b1, 2'b11, 32'h1234_5678, 5'd12);
    #1;
    chk("mid_rst_readys", {b0.req0_ready, b0.req1_ready}, 2'b00);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // Both valid continuously: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!(b0.req0_ready || b0.req1_ready) && n < 50);
      chk($sformatf("grant%0d", i), {b0.req0_ready, b0.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(posedge clock); #1;
    set_req(0, 0, 1'b0, 2'b00, 32'h0, 5'd0);
    set_req(0, 1, 1'b0, 2'b00, 32'h0, 5'd0);
    wait_drain(0);

    // EARLY_EXIT=0 instance: amount 1 still takes 5 shift cycles.
    issue(1, 0, 2'b00, 32'h0000_0001, 5'd1);
    wait_drain(1);

    // Random ops on both instances against the model.
    for (int i = 0; i < 1000; i++) begin
      int d;
      d = (i % 4 == 3) ? 1 : 0;
      issue(d, int'($urandom_range(0, 1)), 2'($urandom), $urandom, 5'($urandom));
      wait_drain(d);
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
